// File: rtl/psum_drain_if.sv
// Handshake bundle for psum_drain: accumulator-side tile stream in,
// requant/writeback word stream out.
interface psum_drain_if #(
  parameter int STAGE_NUM  = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int CW = $clog2(STAGE_NUM);

  logic                  acc_valid_i;
  logic [DATA_WIDTH-1:0] acc_data_i;
  logic [CW-1:0]         acc_depth_i;
  logic                  acc_ready_o;
  logic                  m_valid_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_last_o;
  logic                  m_ready_i;

  modport master (
    output acc_valid_i,
    output acc_data_i,
    output acc_depth_i,
    output m_ready_i,
    input  acc_ready_o,
    input  m_valid_o,
    input  m_data_o,
    input  m_last_o
  );

  modport slave (
    input  acc_valid_i,
    input  acc_data_i,
    input  acc_depth_i,
    input  m_ready_i,
    output acc_ready_o,
    output m_valid_o,
    output m_data_o,
    output m_last_o
  );
endinterface

// File: rtl/psum_drain.sv
// Partial-sum drain: tile-granular capture into a FIFO, registered FWFT out.
// Define PSUM_DRAIN_RELU_EN to clamp negative words to zero on the read side.
module psum_drain #(
  parameter int STAGE_NUM  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TILE_BUF   = 2
) (
  input  logic        clk,
  input  logic        rst,
  psum_drain_if.slave bus,
  output logic [7:0]  tile_cnt_o,
  output logic        ovf_err_o
);

  localparam int DEPTH = TILE_BUF * STAGE_NUM;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(STAGE_NUM);
  localparam logic [AW:0] ROOM = (AW+1)'(DEPTH - STAGE_NUM);

  typedef enum logic {
    IDLE,
    CAPTURE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] depth_q;
  logic [CW-1:0] cnt_q;

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [AW:0]         occ;

  logic                  acc_ready;
  logic                  has_room;
  logic                  start;
  logic                  push;
  logic                  push_last;
  logic                  ovf_set;
  logic                  pop;
  logic                  load;
  logic                  mem_empty;
  logic [DATA_WIDTH:0]   rd_word;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  // occ counts every stored word including the one held in the output
  // register, and is taken before this cycle's pop.
  assign has_room  = (occ <= ROOM);
  assign mem_empty = (wr_ptr == rd_ptr);
  assign pop       = m_valid && bus.m_ready_i;
  assign load      = !mem_empty && (!m_valid || bus.m_ready_i);
  assign rd_word   = mem[rd_ptr[AW-1:0]];

`ifdef PSUM_DRAIN_RELU_EN
  assign rd_data = rd_word[DATA_WIDTH-1] ? '0 : rd_word[DATA_WIDTH-1:0];
`else
  assign rd_data = rd_word[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start && (bus.acc_depth_i != '0)) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (push_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_ready = 1'b0;
    start     = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    ovf_set   = 1'b0;
    unique case (state)
      IDLE: begin
        acc_ready = has_room;
        if (bus.acc_valid_i) begin
          if (has_room) begin
            start     = 1'b1;
            push      = 1'b1;
            push_last = (bus.acc_depth_i == '0);
          end else begin
            ovf_set = 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (bus.acc_valid_i) begin
          push      = 1'b1;
          push_last = (cnt_q == depth_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      depth_q <= bus.acc_depth_i;
      cnt_q   <= CW'(1);
    end else if (push) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {push_last, bus.acc_data_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Output register only reloads when empty or being accepted, so the
  // presented word holds steady under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= rd_data;
      m_last  <= rd_word[DATA_WIDTH];
    end else if (pop) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_cnt_o <= '0;
      ovf_err_o  <= 1'b0;
    end else begin
      if (push_last) begin
        tile_cnt_o <= tile_cnt_o + 1'b1;
      end
      if (ovf_set) begin
        ovf_err_o <= 1'b1;
      end
    end
  end

  assign bus.acc_ready_o = acc_ready;
  assign bus.m_valid_o   = m_valid;
  assign bus.m_data_o    = m_data;
  assign bus.m_last_o    = m_last;

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: tile capture, FWFT output, backpressure,
// overflow, mid-tile reset and a randomly stalled multi-tile run.
module tb_psum_drain;

  localparam int SN = 16;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tile_cnt;
  logic       ovf_err;

  int checks = 0;
  int errors = 0;

  logic [DW:0]   exp_q [$];
  logic [DW-1:0] wbuf [SN];
  logic          held_v = 1'b0;
  logic [DW:0]   held;
  logic          rnd_rdy = 1'b0;
  logic          gaps = 1'b0;

  psum_drain_if #(.STAGE_NUM(SN), .DATA_WIDTH(DW)) bus ();

  psum_drain #(
    .STAGE_NUM (SN),
    .DATA_WIDTH(DW),
    .TILE_BUF  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .tile_cnt_o(tile_cnt),
    .ovf_err_o (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(logic [DW-1:0] w);
`ifdef PSUM_DRAIN_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  task automatic mon();
    logic [DW:0] e;
    if (bus.m_valid_o) begin
      if (held_v) check("hold", {bus.m_last_o, bus.m_data_o}, held);
      if (bus.m_ready_i) begin
        check("extra", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data", bus.m_data_o, e[DW-1:0]);
          check("last", bus.m_last_o, e[DW]);
        end
        held_v = 1'b0;
      end else begin
        held_v = 1'b1;
        held   = {bus.m_last_o, bus.m_data_o};
      end
    end else begin
      held_v = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (!rst) mon();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.m_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic beat(logic [DW-1:0] d, logic [3:0] dep, logic last);
    bus.acc_valid_i = 1'b1;
    bus.acc_data_i  = d;
    bus.acc_depth_i = dep;
    exp_q.push_back({last, model(d)});
    tick();
    bus.acc_valid_i = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.acc_ready_o && n < 1000) begin
      tick();
      n++;
    end
    check("rdy_wait", 64'(bus.acc_ready_o), 1);
  endtask

  task automatic send_tile(logic [3:0] dep);
    wait_ready();
    for (int i = 0; i <= int'(dep); i++) begin
      if (gaps && i != 0 && $urandom_range(0, 3) == 0) tick();
      beat(wbuf[i], dep, i == int'(dep));
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.m_valid_o) && n < 2000) begin
      tick();
      n++;
    end
    check("drain", 64'(exp_q.size()), 0);
  endtask

  initial begin
    bus.acc_valid_i = 1'b0;
    bus.acc_data_i  = '0;
    bus.acc_depth_i = '0;
    bus.m_ready_i   = 1'b1;
    repeat (3) tick();
    check("rst_valid", bus.m_valid_o, 0);
    check("rst_last", bus.m_last_o, 0);
    check("rst_data", bus.m_data_o, 0);
    check("rst_tiles", tile_cnt, 0);
    check("rst_ovf", ovf_err, 0);
    rst = 1'b0;
    tick();
    check("rst_rdy", bus.acc_ready_o, 1);

    // depth 3 tile, m_valid one cycle behind the first write
    beat(32'd10, 4'd3, 1'b0);
    check("fwft_lat0", bus.m_valid_o, 0);
    beat(32'hFFFF_FFFB, 4'd3, 1'b0);
    check("fwft_lat1", bus.m_valid_o, 1);
    beat(32'd7, 4'd3, 1'b0);
    beat(32'd2, 4'd3, 1'b1);
    wait_drain();
    check("t1_tiles", tile_cnt, 1);

    // single-word tile
    beat(32'h7FFF_FFFF, 4'd0, 1'b1);
    check("d0_rdy", bus.acc_ready_o, 1);
    wait_drain();
    check("d0_tiles", tile_cnt, 2);
    check("d0_rdy2", bus.acc_ready_o, 1);

    // fill both tile slots with no downstream acceptance
    bus.m_ready_i = 1'b0;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < SN; i++) wbuf[i] = 32'h100 * t + i - 4;
      send_tile(4'd15);
    end
    check("full_rdy", bus.acc_ready_o, 0);
    check("ovf_pre", ovf_err, 0);
    bus.acc_valid_i = 1'b1;
    bus.acc_data_i  = 32'hDEAD_BEEF;
    bus.acc_depth_i = 4'd0;
    tick();
    bus.acc_valid_i = 1'b0;
    check("ovf_set", ovf_err, 1);
    check("ovf_tiles", tile_cnt, 4);
    bus.m_ready_i = 1'b1;
    repeat (15) tick();
    bus.m_ready_i = 1'b0;
    check("pop15_rdy", bus.acc_ready_o, 0);
    bus.m_ready_i = 1'b1;
    tick();
    bus.m_ready_i = 1'b0;
    check("pop16_rdy", bus.acc_ready_o, 1);
    bus.m_ready_i = 1'b1;
    wait_drain();
    check("ovf_sticky", ovf_err, 1);

    // reset part-way through a tile
    bus.m_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) beat(32'd50 + i, 4'd15, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    held_v = 1'b0;
    check("mrst_valid", bus.m_valid_o, 0);
    check("mrst_tiles", tile_cnt, 0);
    check("mrst_ovf", ovf_err, 0);
    bus.m_ready_i = 1'b1;
    tick();
    check("mrst_quiet", bus.m_valid_o, 0);
    wbuf[0] = 32'd1;
    wbuf[1] = 32'd2;
    wbuf[2] = 32'hFFFF_FFFD;
    wbuf[3] = 32'd4;
    send_tile(4'd3);
    wait_drain();
    check("mrst_tiles2", tile_cnt, 1);

    // random stalls and gaps over many tiles
    rnd_rdy = 1'b1;
    gaps    = 1'b1;
    for (int t = 0; t < 50; t++) begin
      for (int i = 0; i < SN; i++) wbuf[i] = $urandom;
      send_tile(4'($urandom_range(0, 15)));
    end
    wait_drain();
    rnd_rdy = 1'b0;
    check("rnd_tiles", tile_cnt, 51);
    check("rnd_ovf", ovf_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
